// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// opcode/funct values, datapath mux selects, exception causes and the
// decoded-instruction record passed from mc_ctrl_decode to the FSM.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_MEM = 4'd7,
    S_WB_ALU = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_EXC    = 4'd11
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  // PCSource
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_EXC    = 2'd3;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS    = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  // ALUSrcB
  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

  // MemtoReg
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // RegDst
  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  // exc_cause
  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_ILLEGAL = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT = 2'd2;

  // ALU operation class, ALUOp[2:0]
  localparam logic [2:0] ALUC_ADD   = 3'b000;
  localparam logic [2:0] ALUC_SUB   = 3'b001;
  localparam logic [2:0] ALUC_FUNCT = 3'b010;
  localparam logic [2:0] ALUC_AND   = 3'b100;
  localparam logic [2:0] ALUC_SLT   = 3'b101;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_IMM     = 3'd1,
    CLS_MEM     = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } iclass_e;

  typedef struct packed {
    iclass_e cls;
    logic    illegal;
    logic    is_shift;  // sll/srl/sra take shamt on ALU port A
    logic    is_jr;     // jr or jalr: target comes from rs
    logic    is_jalr;
    logic    links;     // jal or jalr write the return address
    logic    is_store;
    logic    is_andi;   // zero-extended immediate
    logic    is_lui;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder for the multi-cycle control FSM.
// Ports: OpCode/Funct in; dec (class + per-instruction flags) and alu_op
// (ALU class for the execute/branch state, bit 3 = OpCode[0]) out.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4
) (
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  output dec_t               dec,
  output logic [ALUOP_W-1:0] alu_op
);

  logic [2:0] alu_cls;

  // Classify the instruction and pick its ALU class
  always_comb begin
    dec.cls      = CLS_ILLEGAL;
    dec.illegal  = 1'b1;
    dec.is_shift = 1'b0;
    dec.is_jr    = 1'b0;
    dec.is_jalr  = 1'b0;
    dec.links    = 1'b0;
    dec.is_store = 1'b0;
    dec.is_andi  = 1'b0;
    dec.is_lui   = 1'b0;
    alu_cls      = ALUC_ADD;

    case (OpCode)
      OP_RTYPE: begin
        dec.cls     = CLS_RTYPE;
        dec.illegal = 1'b0;
        alu_cls     = ALUC_FUNCT;
        case (Funct)
          F_SLL, F_SRL, F_SRA: dec.is_shift = 1'b1;
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: ;
          F_JR: begin
            dec.cls   = CLS_JUMP;
            dec.is_jr = 1'b1;
          end
          F_JALR: begin
            dec.cls     = CLS_JUMP;
            dec.is_jr   = 1'b1;
            dec.is_jalr = 1'b1;
            dec.links   = 1'b1;
          end
          default: begin
            dec.cls     = CLS_ILLEGAL;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_LW, OP_SW: begin
        dec.cls      = CLS_MEM;
        dec.illegal  = 1'b0;
        dec.is_store = (OpCode == OP_SW);
      end
      OP_ADDI, OP_ADDIU, OP_LUI: begin
        dec.cls     = CLS_IMM;
        dec.illegal = 1'b0;
        dec.is_lui  = (OpCode == OP_LUI);
      end
      OP_ANDI: begin
        dec.cls     = CLS_IMM;
        dec.illegal = 1'b0;
        dec.is_andi = 1'b1;
        alu_cls     = ALUC_AND;
      end
      OP_SLTI, OP_SLTIU: begin
        dec.cls     = CLS_IMM;
        dec.illegal = 1'b0;
        alu_cls     = ALUC_SLT;
      end
      OP_BEQ: begin
        dec.cls     = CLS_BRANCH;
        dec.illegal = 1'b0;
        alu_cls     = ALUC_SUB;
      end
      OP_J, OP_JAL: begin
        dec.cls     = CLS_JUMP;
        dec.illegal = 1'b0;
        dec.links   = (OpCode == OP_JAL);
      end
      default: ;
    endcase
  end

  assign alu_op = ALUOP_W'({OpCode[0], alu_cls});

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: a Moore FSM sequencing FETCH/DECODE/EXEC/
// MEM/WB against a unified memory port with a req/ready handshake and a
// timeout watchdog; illegal instructions and memory timeouts trap to EXC.
// Ports: clk, reset_n (async active-low); OpCode/Funct/Zero from the
// datapath; mem_ready from memory; datapath mux selects and write enables;
// exc_cause (registered) and state_o (debug).
// Optional: define MC_CTRL_PERF_EN to add instr_cnt/stall_cnt counters.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TCNT_W      = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtOp,
  output logic               LuOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               EPCWrite,
  output logic [1:0]         exc_cause,
  output logic [STATE_W-1:0] state_o
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]        instr_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  state_e              state_q, state_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [1:0]          exc_cause_q, exc_cause_d;
  logic [1:0]          cause_c;
  logic                mem_state_c;
  logic                tcnt_last_c;
  dec_t                dec;
  logic [ALUOP_W-1:0]  dec_alu_op;

  // Zero only gates the PC in the datapath via PCWriteCond
  logic unused_zero;
  assign unused_zero = Zero;

  mc_ctrl_decode #(
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .OpCode (OpCode),
    .Funct  (Funct),
    .dec    (dec),
    .alu_op (dec_alu_op)
  );

  assign mem_state_c = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                       (state_q == S_MEM_WR);
  // Last waiting cycle: without ready now, the count would hit MEM_TIMEOUT-1
  assign tcnt_last_c = (tcnt_q == TCNT_W'(MEM_TIMEOUT - 2));

  // Next-state and Moore outputs
  always_comb begin
    state_d     = state_q;
    tcnt_d      = '0;
    exc_cause_d = exc_cause_q;
    cause_c     = EXC_NONE;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = PCSRC_ALU;
    RegWrite    = 1'b0;
    RegDst      = RDST_RT;
    MemtoReg    = M2R_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RT;
    ExtOp       = 1'b0;
    LuOp        = 1'b0;
    ALUOp       = ALUOP_W'({OpCode[0], ALUC_ADD});
    EPCWrite    = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (tcnt_last_c) begin
          state_d = S_EXC;
          cause_c = EXC_TIMEOUT;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH2;
        ExtOp   = 1'b1;
        if (dec.illegal) begin
          state_d = S_EXC;
          cause_c = EXC_ILLEGAL;
        end else begin
          case (dec.cls)
            CLS_RTYPE:  state_d = S_EXEC_R;
            CLS_IMM:    state_d = S_EXEC_I;
            CLS_MEM:    state_d = S_ADDR;
            CLS_BRANCH: state_d = S_BRANCH;
            CLS_JUMP:   state_d = S_JUMP;
            default: begin
              state_d = S_EXC;
              cause_c = EXC_ILLEGAL;
            end
          endcase
        end
      end
      S_EXEC_R: begin
        ALUSrcA = dec.is_shift ? SRCA_SHAMT : SRCA_RS;
        ALUOp   = dec_alu_op;
        RegDst  = RDST_RD;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_RS;
        ALUSrcB = SRCB_IMM;
        ExtOp   = ~dec.is_andi;
        LuOp    = dec.is_lui;
        ALUOp   = dec_alu_op;
        state_d = S_WB_ALU;
      end
      S_ADDR: begin
        ALUSrcA = SRCA_RS;
        ALUSrcB = SRCB_IMM;
        ExtOp   = 1'b1;
        state_d = dec.is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD, S_MEM_WR: begin
        IorD     = 1'b1;
        MemRead  = (state_q == S_MEM_RD);
        MemWrite = (state_q == S_MEM_WR);
        if (mem_ready) begin
          state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (tcnt_last_c) begin
          state_d = S_EXC;
          cause_c = EXC_TIMEOUT;
        end
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
        state_d  = S_FETCH;
      end
      S_WB_ALU: begin
        RegWrite = 1'b1;
        RegDst   = (dec.cls == CLS_RTYPE) ? RDST_RD : RDST_RT;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = SRCA_RS;
        ALUOp       = dec_alu_op;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        if (dec.is_jr) begin
          ALUSrcA  = SRCA_RS;
          PCSource = PCSRC_ALU;
        end else begin
          PCSource = PCSRC_JUMP;
        end
        if (dec.links) begin
          RegWrite = 1'b1;
          MemtoReg = M2R_PC;
          RegDst   = dec.is_jalr ? RDST_RD : RDST_RA;
        end
        state_d = S_FETCH;
      end
      S_EXC: begin
        EPCWrite = 1'b1;
        PCWrite  = 1'b1;
        PCSource = PCSRC_EXC;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Watchdog counts only while waiting in the same memory state
    if (mem_state_c && !mem_ready && (state_d == state_q)) begin
      tcnt_d = tcnt_q + TCNT_W'(1);
    end

    if (state_d == S_EXC) begin
      exc_cause_d = cause_c;
    end

    // No architectural write may escape while reset is held
    if (!reset_n) begin
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      EPCWrite    = 1'b0;
    end
  end

  // State, watchdog and cause registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      tcnt_q      <= '0;
      exc_cause_q <= EXC_NONE;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      exc_cause_q <= exc_cause_d;
    end
  end

  assign exc_cause = exc_cause_q;
  assign state_o   = state_q;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Retired-fetch and memory-stall counters, free-running with wrap
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_FETCH) && mem_ready) begin
      instr_cnt_d = instr_cnt_q + 32'd1;
    end
    if (mem_state_c && !mem_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks instructions cycle by cycle
// and compares state and control outputs against hand-derived values.
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
  logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcA, ALUSrcB;
  logic       RegWrite, ExtOp, LuOp, EPCWrite;
  logic [3:0] ALUOp;
  logic [1:0] exc_cause;
  logic [3:0] state_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned rw_cnt   = 0;

  multicycle_control dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .OpCode      (OpCode),
    .Funct       (Funct),
    .Zero        (Zero),
    .mem_ready   (mem_ready),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IorD        (IorD),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PCSource    (PCSource),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ExtOp       (ExtOp),
    .LuOp        (LuOp),
    .ALUOp       (ALUOp),
    .EPCWrite    (EPCWrite),
    .exc_cause   (exc_cause),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply mem_ready for this cycle, let outputs settle, check the state
  task automatic cyc(input logic rdy, input state_e exp_state, input string tag);
    mem_ready = rdy;
    #1;
    check(tag, 32'(state_o), 32'(exp_state));
    if (RegWrite) rw_cnt++;
  endtask

  // One-cycle fetch, then load IR fields and sit in DECODE
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input string tag);
    cyc(1'b1, S_FETCH, {tag, "_fetch"});
    tick();
    OpCode = op;
    Funct  = fn;
    cyc(1'b0, S_DECODE, {tag, "_decode"});
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    OpCode    = 6'h00;
    Funct     = 6'h00;
    Zero      = 1'b0;
    #2;
    check("rst_state", 32'(state_o), 32'(S_FETCH));
    check("rst_exc", 32'(exc_cause), 0);
    check("rst_irwrite", 32'(IRWrite), 0);
    check("rst_pcwrite", 32'(PCWrite), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // lw, 3-cycle fetch and 3-cycle data access
    rw_cnt = 0;
    cyc(1'b0, S_FETCH, "lw_f1");
    check("lw_f1_memread", 32'(MemRead), 1);
    check("lw_f1_aluSrcB", 32'(ALUSrcB), 1);
    check("lw_f1_irwrite", 32'(IRWrite), 0);
    tick();
    cyc(1'b0, S_FETCH, "lw_f2");
    tick();
    cyc(1'b1, S_FETCH, "lw_f3");
    check("lw_f3_irwrite", 32'(IRWrite), 1);
    check("lw_f3_pcwrite", 32'(PCWrite), 1);
    tick();
    OpCode = OP_LW;
    cyc(1'b0, S_DECODE, "lw_dec");
    check("lw_dec_srcB", 32'(ALUSrcB), 3);
    tick();
    cyc(1'b0, S_ADDR, "lw_addr");
    check("lw_addr_srcB", 32'(ALUSrcB), 2);
    tick();
    cyc(1'b0, S_MEM_RD, "lw_m1");
    check("lw_m1_iord", 32'(IorD), 1);
    check("lw_m1_memread", 32'(MemRead), 1);
    tick();
    cyc(1'b0, S_MEM_RD, "lw_m2");
    tick();
    cyc(1'b1, S_MEM_RD, "lw_m3");
    tick();
    cyc(1'b0, S_WB_MEM, "lw_wb");
    check("lw_wb_memtoreg", 32'(MemtoReg), 1);
    tick();
    check("lw_regwrite_count", rw_cnt, 1);

    // beq taken and not taken: control identical in the BRANCH cycle
    for (int z = 1; z >= 0; z--) begin
      Zero = logic'(z);
      fetch_decode(OP_BEQ, 6'h00, "beq");
      cyc(1'b0, S_BRANCH, "beq_br");
      check("beq_pcwritecond", 32'(PCWriteCond), 1);
      check("beq_pcsource", 32'(PCSource), 1);
      check("beq_aluop", 32'(ALUOp), 32'h1);
      tick();
    end

    // Illegal opcode traps
    fetch_decode(6'h3f, 6'h00, "ill");
    cyc(1'b0, S_EXC, "ill_exc");
    check("ill_epcwrite", 32'(EPCWrite), 1);
    check("ill_pcsource", 32'(PCSource), 3);
    check("ill_cause", 32'(exc_cause), 1);
    tick();

    // jal then jalr
    fetch_decode(OP_JAL, 6'h00, "jal");
    cyc(1'b0, S_JUMP, "jal_jump");
    check("jal_regdst", 32'(RegDst), 2);
    check("jal_memtoreg", 32'(MemtoReg), 2);
    check("jal_regwrite", 32'(RegWrite), 1);
    check("jal_pcsource", 32'(PCSource), 2);
    tick();
    fetch_decode(OP_RTYPE, F_JALR, "jalr");
    cyc(1'b0, S_JUMP, "jalr_jump");
    check("jalr_regdst", 32'(RegDst), 1);
    check("jalr_memtoreg", 32'(MemtoReg), 2);
    check("jalr_regwrite", 32'(RegWrite), 1);
    check("jalr_pcsource", 32'(PCSource), 0);
    check("jalr_srcA", 32'(ALUSrcA), 1);
    tick();

    // sll: shamt on port A, R-type writeback to rd
    fetch_decode(OP_RTYPE, F_SLL, "sll");
    cyc(1'b0, S_EXEC_R, "sll_exec");
    check("sll_srcA", 32'(ALUSrcA), 2);
    check("sll_aluop", 32'(ALUOp), 32'h2);
    tick();
    cyc(1'b0, S_WB_ALU, "sll_wb");
    check("sll_regdst", 32'(RegDst), 1);
    check("sll_regwrite", 32'(RegWrite), 1);
    tick();

    // andi: zero-extend, AND class, writeback to rt
    fetch_decode(OP_ANDI, 6'h00, "andi");
    cyc(1'b0, S_EXEC_I, "andi_exec");
    check("andi_extop", 32'(ExtOp), 0);
    check("andi_aluop", 32'(ALUOp), 32'h4);
    tick();
    cyc(1'b0, S_WB_ALU, "andi_wb");
    check("andi_regdst", 32'(RegDst), 0);
    tick();

    // lui: ALUOp[3] follows OpCode[0]
    fetch_decode(OP_LUI, 6'h00, "lui");
    cyc(1'b0, S_EXEC_I, "lui_exec");
    check("lui_luop", 32'(LuOp), 1);
    check("lui_aluop", 32'(ALUOp), 32'h8);
    tick();
    cyc(1'b0, S_WB_ALU, "lui_wb");
    tick();

    // Undefined funct traps
    fetch_decode(OP_RTYPE, 6'h3f, "badfn");
    cyc(1'b0, S_EXC, "badfn_exc");
    check("badfn_cause", 32'(exc_cause), 1);
    tick();

    // sw with memory never ready: 15 waiting cycles then EXC
    fetch_decode(OP_SW, 6'h00, "swto");
    cyc(1'b0, S_ADDR, "swto_addr");
    tick();
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b0, S_MEM_WR, "swto_wait");
      if (i == 15) check("swto_memwrite_last", 32'(MemWrite), 1);
      tick();
    end
    cyc(1'b0, S_EXC, "swto_exc");
    check("swto_memwrite_exc", 32'(MemWrite), 0);
    check("swto_cause", 32'(exc_cause), 2);
    check("swto_epcwrite", 32'(EPCWrite), 1);
    tick();

    // sw with ready on the final count: no exception, cause holds
    fetch_decode(OP_SW, 6'h00, "swok");
    cyc(1'b0, S_ADDR, "swok_addr");
    tick();
    for (int i = 1; i <= 14; i++) begin
      cyc(1'b0, S_MEM_WR, "swok_wait");
      tick();
    end
    cyc(1'b1, S_MEM_WR, "swok_last");
    tick();
    cyc(1'b0, S_FETCH, "swok_back");
    check("swok_cause_hold", 32'(exc_cause), 2);
    tick();

    // Reset in the middle of MEM_RD
    rw_cnt = 0;
    fetch_decode(OP_LW, 6'h00, "rst");
    cyc(1'b0, S_ADDR, "rst_addr");
    tick();
    cyc(1'b0, S_MEM_RD, "rst_mem");
    mem_ready = 1'b1;
    reset_n   = 1'b0;
    #1;
    check("rst_mid_state", 32'(state_o), 32'(S_FETCH));
    check("rst_mid_cause", 32'(exc_cause), 0);
    check("rst_mid_regwrite", 32'(RegWrite), 0);
    check("rst_mid_irwrite", 32'(IRWrite), 0);
    tick();
    reset_n = 1'b1;
    cyc(1'b0, S_FETCH, "rst_after");
    tick();
    check("rst_regwrite_count", rw_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
